// File: rtl/mmcm_drp_ctrl_if.sv
// Handshake and DRP bundle between the MMCM reconfiguration controller and its surroundings.
// The controller uses the master modport; the MMCM/DRP side and the requester use slave.
interface mmcm_drp_ctrl_if;
   logic        start;
   logic [6:0]  div;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic        mmcm_rst;
   logic        locked;
   logic [6:0]  daddr;
   logic        den;
   logic        dwe;
   logic [15:0] di;
   logic [15:0] do_in;
   logic        drdy;

   modport master (
      input  start, div, locked, do_in, drdy,
      output busy, done, err, err_code, mmcm_rst, daddr, den, dwe, di
   );

   modport slave (
      output start, div, locked, do_in, drdy,
      input  busy, done, err, err_code, mmcm_rst, daddr, den, dwe, di
   );
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// Reprograms the MMCM CLKOUT0 divider over DRP: holds the MMCM in reset, read-modify-writes
// ClkReg1/ClkReg2, releases reset and waits for lock. Must run from the free-running board clock.
module mmcm_drp_ctrl #(
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   mmcm_drp_ctrl_if.master bus
);

   localparam int MAX_WAIT = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int TW       = $clog2(MAX_WAIT + 1);
   localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TIMEOUT - 1);
   localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [6:0] CLK_REG1 = 7'h08;
   localparam logic [6:0] CLK_REG2 = 7'h09;

   typedef enum logic [2:0] {
      IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, RST_OFF, LOCK_WAIT
   } CtrlState;

   CtrlState      r_state, w_nextState;
   logic          r_busy, w_nextBusy;
   logic          r_done, w_nextDone;
   logic          r_err, w_nextErr;
   logic [1:0]    r_errCode, w_nextErrCode;
   logic          r_mmcmRst, w_nextMmcmRst;
   logic          r_den, w_nextDen;
   logic          r_dwe, w_nextDwe;
   logic [6:0]    r_daddr, w_nextDaddr;
   logic [15:0]   r_di, w_nextDi;
   logic [5:0]    r_high, w_nextHigh;
   logic [5:0]    r_low, w_nextLow;
   logic          r_edge, w_nextEdge;
   logic          r_noCount, w_nextNoCount;
   logic          r_regIdx, w_nextRegIdx;
   logic [TW-1:0] r_timer, w_nextTimer;
   logic [1:0]    r_lockSync;

   logic          w_divValid;
   logic [5:0]    w_divHigh;
   logic [5:0]    w_divLow;
   logic          w_unusedDoBits;

   // LOW = div - floor(div/2) = ceil(div/2); valid range keeps both fields within 6 bits.
   assign w_divValid = (bus.div != 7'd0) && (bus.div != 7'd127);
   assign w_divHigh  = bus.div[6:1];
   assign w_divLow   = w_divHigh + {5'd0, bus.div[0]};
   assign w_unusedDoBits = ^bus.do_in[7:6];

   always_comb begin
      w_nextState   = r_state;
      w_nextBusy    = r_busy;
      w_nextDone    = 1'b0;
      w_nextErr     = 1'b0;
      w_nextErrCode = r_errCode;
      w_nextMmcmRst = r_mmcmRst;
      w_nextDen     = 1'b0;
      w_nextDwe     = 1'b0;
      w_nextDaddr   = r_daddr;
      w_nextDi      = r_di;
      w_nextHigh    = r_high;
      w_nextLow     = r_low;
      w_nextEdge    = r_edge;
      w_nextNoCount = r_noCount;
      w_nextRegIdx  = r_regIdx;
      w_nextTimer   = r_timer;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               if (!w_divValid) begin
                  w_nextErr     = 1'b1;
                  w_nextErrCode = 2'd1;
               end else begin
                  w_nextErrCode = 2'd0;
                  if (bus.div == 7'd1) begin
                     w_nextHigh    = 6'd1;
                     w_nextLow     = 6'd1;
                     w_nextEdge    = 1'b0;
                     w_nextNoCount = 1'b1;
                  end else begin
                     w_nextHigh    = w_divHigh;
                     w_nextLow     = w_divLow;
                     w_nextEdge    = bus.div[0];
                     w_nextNoCount = 1'b0;
                  end
                  w_nextBusy    = 1'b1;
                  w_nextMmcmRst = 1'b1;
                  w_nextRegIdx  = 1'b0;
                  w_nextState   = RST_ON;
               end
            end
         end
         RST_ON: begin
            w_nextDen   = 1'b1;
            w_nextDaddr = CLK_REG1;
            w_nextState = RD;
         end
         RD: begin
            w_nextTimer = '0;
            w_nextState = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.drdy) begin
               if (!r_regIdx)
                  w_nextDi = {bus.do_in[15:12], r_high, r_low};
               else
                  w_nextDi = {bus.do_in[15:8], r_edge, r_noCount, bus.do_in[5:0]};
               w_nextDen   = 1'b1;
               w_nextDwe   = 1'b1;
               w_nextState = WR;
            end else if (r_timer == DRDY_LAST) begin
               w_nextErr     = 1'b1;
               w_nextErrCode = 2'd2;
               w_nextMmcmRst = 1'b0;
               w_nextBusy    = 1'b0;
               w_nextState   = IDLE;
            end else begin
               w_nextTimer = r_timer + TW'(1);
            end
         end
         WR: begin
            w_nextTimer = '0;
            w_nextState = WR_WAIT;
         end
         WR_WAIT: begin
            if (bus.drdy) begin
               if (!r_regIdx) begin
                  w_nextRegIdx = 1'b1;
                  w_nextDaddr  = CLK_REG2;
                  w_nextDen    = 1'b1;
                  w_nextState  = RD;
               end else begin
                  w_nextMmcmRst = 1'b0;
                  w_nextTimer   = '0;
                  w_nextState   = RST_OFF;
               end
            end else if (r_timer == DRDY_LAST) begin
               w_nextErr     = 1'b1;
               w_nextErrCode = 2'd2;
               w_nextMmcmRst = 1'b0;
               w_nextBusy    = 1'b0;
               w_nextState   = IDLE;
            end else begin
               w_nextTimer = r_timer + TW'(1);
            end
         end
         // The lock window starts counting in the cycle the MMCM reset is released.
         RST_OFF: begin
            w_nextTimer = r_timer + TW'(1);
            w_nextState = LOCK_WAIT;
         end
         LOCK_WAIT: begin
            if (r_lockSync[1]) begin
               w_nextDone  = 1'b1;
               w_nextBusy  = 1'b0;
               w_nextState = IDLE;
            end else if (r_timer == LOCK_LAST) begin
               w_nextErr     = 1'b1;
               w_nextErrCode = 2'd3;
               w_nextBusy    = 1'b0;
               w_nextState   = IDLE;
            end else begin
               w_nextTimer = r_timer + TW'(1);
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_errCode  <= 2'd0;
         r_mmcmRst  <= 1'b0;
         r_den      <= 1'b0;
         r_dwe      <= 1'b0;
         r_daddr    <= 7'd0;
         r_di       <= 16'd0;
         r_high     <= 6'd0;
         r_low      <= 6'd0;
         r_edge     <= 1'b0;
         r_noCount  <= 1'b0;
         r_regIdx   <= 1'b0;
         r_timer    <= '0;
         r_lockSync <= 2'b00;
      end else begin
         r_state    <= w_nextState;
         r_busy     <= w_nextBusy;
         r_done     <= w_nextDone;
         r_err      <= w_nextErr;
         r_errCode  <= w_nextErrCode;
         r_mmcmRst  <= w_nextMmcmRst;
         r_den      <= w_nextDen;
         r_dwe      <= w_nextDwe;
         r_daddr    <= w_nextDaddr;
         r_di       <= w_nextDi;
         r_high     <= w_nextHigh;
         r_low      <= w_nextLow;
         r_edge     <= w_nextEdge;
         r_noCount  <= w_nextNoCount;
         r_regIdx   <= w_nextRegIdx;
         r_timer    <= w_nextTimer;
         r_lockSync <= {r_lockSync[0], bus.locked};
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.err_code = r_errCode;
   assign bus.mmcm_rst = r_mmcmRst;
   assign bus.den      = r_den;
   assign bus.dwe      = r_dwe;
   assign bus.daddr    = r_daddr;
   assign bus.di       = r_di;

endmodule
